// File: rtl/fifo_unpacker_pkg.sv
// Shared types and elaboration helpers for the FIFO word unpacker.
// Optional feature macro (used by fifo_unpacker): FIFO_UNPACKER_LAST_EN.
package fifo_unpacker_pkg;

  // Unpacker control states
  //   state   | meaning
  //   IDLE    | waiting for a non-empty FIFO and an expired read holdoff
  //   CAPTURE | fifo_q is valid this cycle; latch it into the shift register
  //   SHIFT   | presenting beats MSB-first until the last one is accepted
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2
  } state_t;

  // Number of OUT_WIDTH beats per FIFO word.
  function automatic int calc_beats(input int data_width, input int out_width);
    return data_width / out_width;
  endfunction

  // Index/counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int calc_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rd_holdoff.sv
// Read-spacing timer: a down-counter loaded on each FIFO pop. While it is
// nonzero the registered empty flag may still describe the pre-pop pointers,
// so the unpacker must not issue another read.
module fifo_rd_holdoff
  import fifo_unpacker_pkg::*;
#(
  parameter int RD_HOLDOFF = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_expired
);

  localparam int CW = calc_idx_w(RD_HOLDOFF);
  // Loading N-1 means the earliest next pop is exactly N cycles later.
  localparam logic [CW-1:0] LOAD_VAL = CW'(RD_HOLDOFF - 1);

  logic [CW-1:0] r_cnt;

  // Load on a pop, otherwise count down to zero and hold there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/fifo_unpacker.sv
// FIFO word unpacker: pops one DATA_WIDTH word at a time from a FIFO with a
// registered (lagging) empty flag and serialises it MSB-first into
// OUT_WIDTH beats on a valid/ready stream.
// Optional feature macro: FIFO_UNPACKER_LAST_EN adds out_last, high with the
// final beat of every word.
module fifo_unpacker
  import fifo_unpacker_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int OUT_WIDTH  = 32,
  parameter int RD_HOLDOFF = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_mty,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  output logic                  fifo_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_cnt
`ifdef FIFO_UNPACKER_LAST_EN
  ,
  output logic                  out_last
`endif
);

  localparam int BEATS = calc_beats(DATA_WIDTH, OUT_WIDTH);
  localparam int BW    = calc_idx_w(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  generate
    if ((DATA_WIDTH % OUT_WIDTH) != 0) begin : g_bad_width
      $error("fifo_unpacker: DATA_WIDTH must be an integer multiple of OUT_WIDTH");
    end
    if (RD_HOLDOFF < 3) begin : g_bad_holdoff
      $error("fifo_unpacker: RD_HOLDOFF must be at least 3 to cover the empty-flag lag");
    end
  endgenerate

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_word;
  logic [BW-1:0]         r_beat;
  logic                  r_out_valid;
  logic [CNT_WIDTH-1:0]  r_words_cnt;
  logic                  w_rd;
  logic                  w_expired;
  logic                  w_accept;
  logic                  w_last_beat;

  assign w_accept    = r_out_valid & out_ready;
  assign w_last_beat = (r_beat == LAST_BEAT);

  fifo_rd_holdoff #(
    .RD_HOLDOFF(RD_HOLDOFF)
  ) u_holdoff (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_rd),
    .o_expired(w_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and the pop strobe. The strobe is gated by rst so that
  // a reset cycle can never consume a FIFO word that would then be dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst && !fifo_mty && w_expired) begin
          w_rd        = 1'b1;
          w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (w_accept && w_last_beat) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Word capture, beat stepping and word counting. The word is shifted left
  // on each non-final accept so the current beat always sits in the top
  // OUT_WIDTH bits; nothing moves while a beat is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word      <= '0;
      r_beat      <= '0;
      r_out_valid <= 1'b0;
      r_words_cnt <= '0;
    end else begin
      case (r_state)
        CAPTURE: begin
          r_word      <= fifo_q;
          r_beat      <= '0;
          r_out_valid <= 1'b1;
        end
        SHIFT: begin
          if (w_accept) begin
            if (w_last_beat) begin
              r_out_valid <= 1'b0;
              r_words_cnt <= r_words_cnt + CNT_WIDTH'(1);
            end else begin
              r_beat <= r_beat + BW'(1);
              r_word <= r_word << OUT_WIDTH;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fifo_rd   = w_rd;
  assign out_valid = r_out_valid;
  assign out_data  = r_word[DATA_WIDTH-1 -: OUT_WIDTH];
  assign busy      = (r_state != IDLE);
  assign words_cnt = r_words_cnt;

`ifdef FIFO_UNPACKER_LAST_EN
  assign out_last = r_out_valid & w_last_beat;
`endif

endmodule

// File: tb/tb_fifo_unpacker.sv
// Self-checking bench for fifo_unpacker: a 4-beat instance fed by a small
// FIFO model with a lagging empty flag, plus a 1-beat instance
// (OUT_WIDTH == DATA_WIDTH) checking minimum read spacing.
// Honours FIFO_UNPACKER_LAST_EN when defined.
module tb_fifo_unpacker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- instance 1: 128 -> 4 x 32 ----------------
  logic         fifo_mty = 1'b1;
  logic [127:0] fifo_q   = '0;
  logic         fifo_rd;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         busy;
  logic [15:0]  words_cnt;
  logic         out_last;

  fifo_unpacker u_dut (
    .clk      (clk),
    .rst      (rst),
    .fifo_mty (fifo_mty),
    .fifo_q   (fifo_q),
    .fifo_rd  (fifo_rd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .words_cnt(words_cnt)
`ifdef FIFO_UNPACKER_LAST_EN
    ,
    .out_last (out_last)
`endif
  );
`ifndef FIFO_UNPACKER_LAST_EN
  assign out_last = 1'b0;
`endif

  // FIFO model: registered empty computed from the pre-update pointers.
  logic [127:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [31:0] exp_q [$];

  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_q <= mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end
    fifo_mty <= (wr_ptr == rd_ptr);
  end

  task automatic push_word(input logic [127:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr++;
    for (int j = 0; j < 4; j++) exp_q.push_back(w[127-32*j -: 32]);
  endtask

  int rd_hist [0:255];
  int n_rd = 0;
  int n_acc = 0;
  int last_acc_cyc = 0;
  int last_rd_cyc = -100;
  logic prev_stall = 1'b0;
  logic prev_valid = 1'b0;
  logic [31:0] prev_data = '0;

  // Instance 1 monitor: beat order, stall stability, spacing, latency.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      chk("rd_in_reset", fifo_rd, 1'b0);
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, prev_data);
      end
      if (fifo_rd) begin
        chk("rd_spacing", (cyc - last_rd_cyc) >= 3, 1'b1);
        chk("fifo_underflow", wr_ptr != rd_ptr, 1'b1);
        last_rd_cyc = cyc;
        rd_hist[n_rd % 256] = cyc;
        n_rd++;
      end
      if (out_valid && !prev_valid && n_rd > 0)
        chk("first_beat_lat", cyc - rd_hist[(n_rd-1) % 256], 2);
      if (out_valid && out_ready) begin
        chk("beat_avail", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
`ifdef FIFO_UNPACKER_LAST_EN
          chk("out_last", out_last, exp_q.size() == 1);
`endif
          e = exp_q.pop_front();
          chk("beat_data", out_data, e);
        end
        n_acc++;
        last_acc_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_data  = out_data;
    end
  end

  // Downstream ready: constant 1, or LFSR-driven when ready_mode is set.
  logic ready_mode = 1'b0;
  initial begin
    logic [15:0] lfsr;
    lfsr = 16'hACE1;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      out_ready = ready_mode ? lfsr[0] : 1'b1;
    end
  end

  // ---------------- instance 2: 128 -> 1 x 128 ----------------
  logic         fifo_mty2 = 1'b1;
  logic [127:0] fifo_q2   = '0;
  logic         fifo_rd2;
  logic         out_valid2;
  logic         out_ready2 = 1'b1;
  logic [127:0] out_data2;
  logic         busy2;
  logic [15:0]  words_cnt2;
  logic         out_last2;

  fifo_unpacker #(.OUT_WIDTH(128)) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .fifo_mty (fifo_mty2),
    .fifo_q   (fifo_q2),
    .fifo_rd  (fifo_rd2),
    .out_valid(out_valid2),
    .out_ready(out_ready2),
    .out_data (out_data2),
    .busy     (busy2),
    .words_cnt(words_cnt2)
`ifdef FIFO_UNPACKER_LAST_EN
    ,
    .out_last (out_last2)
`endif
  );
`ifndef FIFO_UNPACKER_LAST_EN
  assign out_last2 = 1'b0;
`endif

  int pushed2 = 0;
  int popped2 = 0;

  // Second FIFO model: word k is four copies of C0DE0000|k.
  always @(posedge clk) begin
    if (fifo_rd2) begin
      fifo_q2 <= {4{32'hC0DE0000 | 32'(popped2)}};
      popped2 <= popped2 + 1;
    end
    fifo_mty2 <= (pushed2 == popped2);
  end

  int n_acc2 = 0;
  int last_acc2 = 0;
  int first_rd2 = -1;
  int last_rd2 = -100;
  logic prev_valid2 = 1'b0;

  // Instance 2 monitor: data, spacing, last flag.
  always @(negedge clk) begin
    if (rst) begin
      chk("rd2_in_reset", fifo_rd2, 1'b0);
      prev_valid2 = 1'b0;
    end else begin
      if (fifo_rd2) begin
        chk("rd2_spacing", (cyc - last_rd2) >= 3, 1'b1);
        chk("fifo2_underflow", pushed2 != popped2, 1'b1);
        if (first_rd2 < 0) first_rd2 = cyc;
        last_rd2 = cyc;
      end
      if (out_valid2 && !prev_valid2)
        chk("first_beat_lat2", cyc - last_rd2, 2);
      if (out_valid2 && out_ready2) begin
        chk("beat2_data", out_data2, {4{32'hC0DE0000 | 32'(n_acc2)}});
`ifdef FIFO_UNPACKER_LAST_EN
        chk("out_last2", out_last2, 1'b1);
`endif
        n_acc2++;
        last_acc2 = cyc;
      end
      prev_valid2 = out_valid2;
    end
  end

  task automatic wait_drain(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Directed sequence.
  initial begin
    int base_rd;
    int base_acc;
    logic rd_seen, busy_seen, v_seen;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fifo_rd", fifo_rd, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_words_cnt", words_cnt, 16'd0);
    chk("rst_out_last", out_last, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Empty FIFO for 20 cycles: nothing happens.
    rd_seen = 1'b0; busy_seen = 1'b0; v_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rd_seen   = rd_seen | fifo_rd | fifo_rd2;
      busy_seen = busy_seen | busy | busy2;
      v_seen    = v_seen | out_valid | out_valid2;
    end
    chk("empty_no_rd", rd_seen, 1'b0);
    chk("empty_no_busy", busy_seen, 1'b0);
    chk("empty_no_valid", v_seen, 1'b0);

    // Reset while beat 2 is presented: word discarded, count unchanged (0).
    @(posedge clk);
    #1;
    base_acc = n_acc;
    push_word(128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (n_acc - base_acc == 2) break;
    end
    chk("mid_reach_beat2", n_acc - base_acc, 2);
    chk("mid_valid_before", out_valid, 1'b1);
    chk("mid_data_before", out_data, 32'hE2E2E2E2);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cnt", words_cnt, 16'd0);

    // Single word, continuous ready: restarts from beat 0.
    @(posedge clk);
    #1;
    base_rd = n_rd;
    push_word(128'h00112233_44556677_8899AABB_CCDDEEFF);
    wait_drain("single_drain", 60);
    chk("single_rds", n_rd - base_rd, 1);
    chk("single_span", last_acc_cyc - rd_hist[base_rd % 256], 5);
    chk("single_cnt", words_cnt, 16'd1);

    // Eight words back to back: reads every BEATS+2 = 6 cycles.
    @(posedge clk);
    #1;
    base_rd = n_rd;
    for (int k = 0; k < 8; k++)
      push_word({32'hB0000000 + 32'(k << 8) + 32'd0, 32'hB0000000 + 32'(k << 8) + 32'd1,
                 32'hB0000000 + 32'(k << 8) + 32'd2, 32'hB0000000 + 32'(k << 8) + 32'd3});
    wait_drain("burst_drain", 200);
    chk("burst_rds", n_rd - base_rd, 8);
    chk("burst_span", last_acc_cyc - rd_hist[base_rd % 256], 47);
    chk("burst_cnt", words_cnt, 16'd9);

    // Pseudo-random backpressure.
    @(posedge clk);
    #1;
    ready_mode = 1'b1;
    push_word(128'hD0000001_D0000002_D0000003_D0000004);
    push_word(128'hD1111111_D2222222_D3333333_D4444444);
    push_word(128'h0000000F_000000F0_00000F00_0000F000);
    push_word(128'hFFFFFFFF_00000000_FFFFFFFF_00000000);
    wait_drain("stall_drain", 600);
    ready_mode = 1'b0;
    chk("stall_cnt", words_cnt, 16'd13);

    // Single-beat instance: five words at minimum spacing of 3 cycles.
    @(posedge clk);
    #1 pushed2 = 5;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (n_acc2 == 5 && !busy2) break;
    end
    chk("w1_beats", n_acc2, 5);
    chk("w1_cnt", words_cnt2, 16'd5);
    chk("w1_span", last_acc2 - first_rd2, 14);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
